// File: rtl/request_encoder.sv
// rtl/request_encoder.sv - registered 8-to-3 multi-hot request encoder, one code per set bit, LSB first
module request_encoder #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] in_bits,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_code,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         empty_pulse
);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t       state, state_n;
    logic [N-1:0] pending, pending_n;
    logic [N-1:0] remaining;
    logic [W-1:0] code_n;
    logic         valid_n, last_n, empty_n;

    function automatic logic [W-1:0] lowest_index(input logic [N-1:0] v);
        lowest_index = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (v[i]) lowest_index = W'(i);
        end
    endfunction

    function automatic logic single_bit(input logic [N-1:0] v);
        single_bit = (v != '0) && ((v & (v - N'(1))) == '0);
    endfunction

    assign in_ready  = (state == IDLE);
    // the bit being handed over this cycle is always the one out_code names
    assign remaining = pending & ~({{(N-1){1'b0}}, 1'b1} << out_code);

    always_comb begin
        state_n   = state;
        pending_n = pending;
        code_n    = out_code;
        valid_n   = out_valid;
        last_n    = out_last;
        empty_n   = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (in_bits != '0) begin
                        pending_n = in_bits;
                        code_n    = lowest_index(in_bits);
                        valid_n   = 1'b1;
                        last_n    = single_bit(in_bits);
                        state_n   = EMIT;
                    end else begin
                        empty_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_valid && out_ready) begin
                    pending_n = remaining;
                    if (remaining != '0) begin
                        code_n = lowest_index(remaining);
                        last_n = single_bit(remaining);
                    end else begin
                        code_n  = '0;
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= '0;
            out_code    <= '0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            empty_pulse <= 1'b0;
        end else begin
            state       <= state_n;
            pending     <= pending_n;
            out_code    <= code_n;
            out_valid   <= valid_n;
            out_last    <= last_n;
            empty_pulse <= empty_n;
        end
    end

endmodule

// File: tb/tb_request_encoder.sv
// tb/tb_request_encoder.sv - directed scoreboard bench for request_encoder
module tb_request_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] in_bits = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic       empty_pulse;

    int         tests = 0;
    int         failed = 0;
    logic [3:0] sb[$];
    logic [7:0] decoded;

    request_encoder #(.N(8), .W(3)) dut (
        .clk(clk),
        .reset(reset),
        .in_bits(in_bits),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out_code(out_code),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .empty_pulse(empty_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_vector(input logic [7:0] v);
        logic [7:0] rest;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                rest = v >> (i + 1);
                sb.push_back({(rest == 8'h00), 3'(i)});
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // consumes every queued code with out_ready high; codes must arrive back to back
    task automatic drain(input string tag, input int expected_cycles, input bit poke);
        int         cycles;
        logic [3:0] exp;
        cycles    = 0;
        out_ready = 1'b1;
        while (sb.size() > 0 && cycles < 20) begin
            if (poke) begin
                in_bits  = 8'h01;
                in_valid = cycles[0];
            end
            check({tag, "_valid"}, 32'(out_valid), 32'd1);
            if (out_valid) begin
                exp = sb.pop_front();
                check({tag, "_code"}, 32'(out_code), 32'(exp[2:0]));
                check({tag, "_last"}, 32'(out_last), 32'(exp[3]));
                decoded = decoded | (8'h01 << out_code);
            end
            step();
            cycles++;
        end
        in_valid = 1'b0;
        check({tag, "_cycles"}, 32'(cycles), 32'(expected_cycles));
    endtask

    initial begin
        // reset asserted mid-cycle while an all-ones vector is offered
        #2;
        reset    = 1'b1;
        in_valid = 1'b1;
        in_bits  = 8'hFF;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_code", 32'(out_code), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_empty", 32'(empty_pulse), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        step();
        step();
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        reset    = 1'b0;

        // basic stream: A4 -> 2, 5, 7
        in_bits  = 8'hA4;
        in_valid = 1'b1;
        out_ready = 1'b1;
        check("basic_in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        push_vector(8'hA4);
        check("basic_busy", 32'(in_ready), 32'd0);
        drain("basic", 3, 1'b0);
        check_idle("basic_end");

        // backpressure: 81 held for three cycles
        out_ready = 1'b0;
        in_bits   = 8'h81;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        push_vector(8'h81);
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_code", 32'(out_code), 32'd0);
            check("bp_last", 32'(out_last), 32'd0);
            step();
        end
        drain("bp", 2, 1'b0);
        check_idle("bp_end");

        // empty vector followed by an immediate load
        in_bits  = 8'h00;
        in_valid = 1'b1;
        step();
        check("empty_pulse_hi", 32'(empty_pulse), 32'd1);
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_in_ready", 32'(in_ready), 32'd1);
        in_bits = 8'h10;
        step();
        in_valid = 1'b0;
        check("empty_pulse_lo", 32'(empty_pulse), 32'd0);
        push_vector(8'h10);
        drain("after_empty", 1, 1'b0);
        check_idle("after_empty_end");

        // full vector with in_valid pokes during emission
        in_bits  = 8'hFF;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        push_vector(8'hFF);
        decoded = 8'h00;
        drain("full", 8, 1'b1);
        check("full_decoded", 32'(decoded), 32'hFF);
        check_idle("full_end");
        step();
        check("full_no_accept", 32'(out_valid), 32'd0);

        // reset in the middle of F0
        in_bits  = 8'hF0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check("mid_code4", 32'(out_code), 32'd4);
        step();
        check("mid_code5", 32'(out_code), 32'd5);
        step();
        check("mid_code6", 32'(out_code), 32'd6);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_code", 32'(out_code), 32'd0);
        check("mid_rst_last", 32'(out_last), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        reset    = 1'b0;
        in_bits  = 8'h02;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        push_vector(8'h02);
        drain("post_rst", 1, 1'b0);
        check_idle("post_rst_end");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
